periph_bus_arbiter: RTL and testbench
=====================================

Name: periph_bus_arbiter

Overview:
Shares the single memory-mapped peripheral port used by the simulated UART (cs / addr / wdata / bytesel / ack / rdata) between two bus requesters, e.g. the picorv32 data port and a debug/loader master. Each request becomes exactly one single-cycle chip-select strobe, so the slave never sees a repeated write. The block waits for the slave's registered ack, returns read data to the winning requester, and terminates hung accesses with a timeout error. Round-robin arbitration gives fair access.

Parameters:
TIMEOUT, 16, max cycles waited for slv_ack after the strobe before an error completion; legal range 2..255.
CW, $clog2(TIMEOUT+1), width of the wait counter (derived; do not override).

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous assert, active-low
m0_req  in  1  requester 0 access request; held high until m0_ack
m0_addr  in  32  requester 0 byte address
m0_wdata  in  32  requester 0 write data
m0_bytesel  in  4  requester 0 byte enables; 4'b0001 = byte write, anything else = read
m0_ack  out  1  one-cycle completion pulse to requester 0
m0_rdata  out  32  read data, valid while m0_ack=1
m0_err  out  1  timeout flag, valid while m0_ack=1
m1_req, m1_addr, m1_wdata, m1_bytesel, m1_ack, m1_rdata, m1_err  same as the m0_* group, for requester 1
slv_cs  out  1  chip select to the peripheral
slv_addr  out  32  address to the peripheral
slv_wdata  out  32  write data to the peripheral
slv_bytesel  out  4  byte enables to the peripheral
slv_ack  in  1  peripheral ack; high one cycle after the cycle in which slv_cs was high
slv_rdata  in  32  peripheral read data, valid with slv_ack
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state=IDLE; wait counter=0; last_grant=1, so m0 wins the first tie.
- All outputs are registered. State machine states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - Only one req high: grant that requester.
  - Both req high: grant the requester that is not last_grant.
  - On a grant, latch addr/wdata/bytesel into slv_* and the grant index, then go to STROBE.
- STROBE: slv_cs=1 for exactly one cycle; wait counter cleared; go to WAIT.
- WAIT:
  - slv_cs=0.
  - slv_ack=1: capture slv_rdata, err=0, go to RESP. Normal latency: slv_ack arrives in the first WAIT cycle.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ack: rdata=32'hDEAD_BEEF, err=1, go to RESP.
  - slv_ack and timeout in the same cycle: the ack wins, err=0.
- RESP:
  - Pulse the granted mN_ack for one cycle, with mN_rdata and mN_err valid.
  - last_grant <= granted index; go to IDLE.
  - mN_rdata holds its value after the pulse. mN_err returns to 0.
- Latency: grant edge to mN_ack is 3 cycles with a prompt slave; minimum request-to-request period is 4 cycles.
- slv_addr, slv_wdata and slv_bytesel hold their latched values until the next grant.
- Requester rule: deassert req on the edge that observes ack. A req still high in IDLE is treated as a new transaction.
- req dropped mid-transaction: ignored; the transaction completes and the ack is still pulsed.
- A slv_ack outside WAIT is ignored and does not change state.
- resetn low in any state: immediate return to reset values. An in-flight transaction is abandoned and no ack is issued.
- m0_ack and m1_ack are never high in the same cycle.

Decomposition:
- Package periph_arb_pkg holds:
  - the state enum {IDLE, STROBE, WAIT, RESP};
  - localparam TIMEOUT_DATA = 32'hDEAD_BEEF;
  - localparam BYTESEL_WRITE = 4'b0001;
  - requester index constants M0=1'b0, M1=1'b1.
- One sub-module, rr_pick2: combinational two-way round-robin picker. Inputs req[1:0] and last; outputs gnt_valid and gnt_idx.

Test Plan:
- Single write: m0 requests addr 0x0, wdata 0x41, bytesel 0001 -> slv_cs high exactly 1 cycle with slv_wdata=0x41; m0_ack 3 cycles after the grant edge; m0_err=0; m1_ack stays 0.
- Read: m1 requests addr 0x4, bytesel 1111; slave returns 0x2 -> m1_rdata=0x0000_0002 with m1_ack; slv_cs pulsed once.
- Contention: m0_req and m1_req both held high for 4 back-to-back transactions from reset -> grant order m0, m1, m0, m1; never two acks in one cycle.
- Timeout: slave never acks, TIMEOUT=16 -> m0_ack fires 16 cycles after STROBE with m0_rdata=0xDEADBEEF and m0_err=1; the next request completes normally.
- Spurious ack: slv_ack pulsed while in IDLE -> no state change, no mN_ack, busy stays 0.
- Reset mid-WAIT: resetn low for 1 cycle during WAIT -> all outputs 0 immediately, no ack issued; the next tie grants m0.

Source files
------------

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester peripheral bus arbiter.
// Imported by the arbiter, its round-robin picker and the testbench.
package periph_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA  = 32'hDEAD_BEEF;
  localparam logic [3:0]  BYTESEL_WRITE = 4'b0001;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// Bundle of the two requester ports, the peripheral port and busy.
// slave modport: the arbiter; master modport: requesters plus peripheral model.
interface periph_bus_arbiter_if;

  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_bytesel;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_bytesel;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        slv_cs;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_bytesel;
  logic        slv_ack;
  logic [31:0] slv_rdata;

  logic        busy;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_bytesel,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_addr, m1_wdata, m1_bytesel,
    output m1_ack, m1_rdata, m1_err,
    output slv_cs, slv_addr, slv_wdata, slv_bytesel,
    input  slv_ack, slv_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_bytesel,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_addr, m1_wdata, m1_bytesel,
    input  m1_ack, m1_rdata, m1_err,
    input  slv_cs, slv_addr, slv_wdata, slv_bytesel,
    output slv_ack, slv_rdata,
    input  busy
  );

endinterface

// File: rtl/periph_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester
// that did not win last time is chosen.
module rr_pick2
  import periph_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = M0;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else if (req[1]) begin
      gnt_idx = M1;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares one memory-mapped peripheral port between two requesters; every
// request becomes a single-cycle chip-select strobe with timeout protection.
module periph_bus_arbiter
  import periph_arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input logic                clk,
  input logic                resetn,
  periph_bus_arbiter_if.slave bus
);

  // state  | meaning
  // IDLE   | sample requests, latch the winner's address/data
  // STROBE | slv_cs high for this single cycle, counter cleared
  // WAIT   | wait for slv_ack or the timeout
  // RESP   | granted mN_ack high with rdata/err, update last_grant

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_grant, last_grant_nxt;
  logic          gnt, gnt_nxt;

  logic          slv_cs, slv_cs_nxt;
  logic [31:0]   slv_addr, slv_addr_nxt;
  logic [31:0]   slv_wdata, slv_wdata_nxt;
  logic [3:0]    slv_bytesel, slv_bytesel_nxt;
  logic          m0_ack, m0_ack_nxt;
  logic [31:0]   m0_rdata, m0_rdata_nxt;
  logic          m0_err, m0_err_nxt;
  logic          m1_ack, m1_ack_nxt;
  logic [31:0]   m1_rdata, m1_rdata_nxt;
  logic          m1_err, m1_err_nxt;
  logic          busy, busy_nxt;

  logic          pick_valid, pick_idx;
  logic          done, done_err;
  logic [31:0]   done_data;
  logic [31:0]   sel_addr, sel_wdata;
  logic [3:0]    sel_bytesel;

  rr_pick2 u_pick (
    .req       ({bus.m1_req, bus.m0_req}),
    .last      (last_grant),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  assign sel_addr    = (pick_idx == M1) ? bus.m1_addr    : bus.m0_addr;
  assign sel_wdata   = (pick_idx == M1) ? bus.m1_wdata   : bus.m0_wdata;
  assign sel_bytesel = (pick_idx == M1) ? bus.m1_bytesel : bus.m0_bytesel;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    last_grant_nxt  = last_grant;
    gnt_nxt         = gnt;
    slv_cs_nxt      = 1'b0;
    slv_addr_nxt    = slv_addr;
    slv_wdata_nxt   = slv_wdata;
    slv_bytesel_nxt = slv_bytesel;
    m0_ack_nxt      = 1'b0;
    m0_rdata_nxt    = m0_rdata;
    m0_err_nxt      = 1'b0;
    m1_ack_nxt      = 1'b0;
    m1_rdata_nxt    = m1_rdata;
    m1_err_nxt      = 1'b0;
    done            = 1'b0;
    done_data       = TIMEOUT_DATA;
    done_err        = 1'b1;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt       = STROBE;
          gnt_nxt         = pick_idx;
          slv_cs_nxt      = 1'b1;
          slv_addr_nxt    = sel_addr;
          slv_wdata_nxt   = sel_wdata;
          slv_bytesel_nxt = sel_bytesel;
        end
      end
      STROBE: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        // An ack landing on the last counted cycle still wins over the timeout.
        if (bus.slv_ack) begin
          done      = 1'b1;
          done_data = bus.slv_rdata;
          done_err  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          done = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP: begin
        state_nxt      = IDLE;
        last_grant_nxt = gnt;
      end
      default: state_nxt = IDLE;
    endcase

    if (done) begin
      state_nxt = RESP;
      if (gnt == M0) begin
        m0_ack_nxt   = 1'b1;
        m0_rdata_nxt = done_data;
        m0_err_nxt   = done_err;
      end else begin
        m1_ack_nxt   = 1'b1;
        m1_rdata_nxt = done_data;
        m1_err_nxt   = done_err;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= M1;
      gnt         <= M0;
      slv_cs      <= 1'b0;
      slv_addr    <= '0;
      slv_wdata   <= '0;
      slv_bytesel <= '0;
      m0_ack      <= 1'b0;
      m0_rdata    <= '0;
      m0_err      <= 1'b0;
      m1_ack      <= 1'b0;
      m1_rdata    <= '0;
      m1_err      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last_grant  <= last_grant_nxt;
      gnt         <= gnt_nxt;
      slv_cs      <= slv_cs_nxt;
      slv_addr    <= slv_addr_nxt;
      slv_wdata   <= slv_wdata_nxt;
      slv_bytesel <= slv_bytesel_nxt;
      m0_ack      <= m0_ack_nxt;
      m0_rdata    <= m0_rdata_nxt;
      m0_err      <= m0_err_nxt;
      m1_ack      <= m1_ack_nxt;
      m1_rdata    <= m1_rdata_nxt;
      m1_err      <= m1_err_nxt;
      busy        <= busy_nxt;
    end
  end

  assign bus.slv_cs      = slv_cs;
  assign bus.slv_addr    = slv_addr;
  assign bus.slv_wdata   = slv_wdata;
  assign bus.slv_bytesel = slv_bytesel;
  assign bus.m0_ack      = m0_ack;
  assign bus.m0_rdata    = m0_rdata;
  assign bus.m0_err      = m0_err;
  assign bus.m1_ack      = m1_ack;
  assign bus.m1_rdata    = m1_rdata;
  assign bus.m1_err      = m1_err;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: directed vector table, corner
// sequences, and random traffic against a cycle-schedule reference model.
module tb_periph_bus_arbiter;
  import periph_arb_pkg::*;

  localparam int T = 16;
  localparam int N_RND = 900;
  localparam int DEPTH = 1300;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  periph_bus_arbiter_if bus();

  periph_bus_arbiter #(.TIMEOUT(T)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Peripheral model: acks one cycle after a strobe unless muted for it.
  logic        cs_prev = 1'b0;
  logic        mute_prev = 1'b0;
  logic        slv_mute = 1'b0;
  logic        spur_next = 1'b0;
  logic [31:0] addr_prev = '0;

  typedef struct {
    logic        idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bs;
    logic        mute;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs[5];

  logic        exp_cs[DEPTH];
  logic        exp_busy[DEPTH];
  logic        exp_ack0[DEPTH];
  logic        exp_ack1[DEPTH];
  logic [31:0] exp_rd[DEPTH];
  logic        exp_err[DEPTH];
  logic [31:0] exp_addr[DEPTH];
  logic [31:0] exp_wd[DEPTH];
  logic [3:0]  exp_bs[DEPTH];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    bus.slv_ack   = (cs_prev && !mute_prev) || spur_next;
    bus.slv_rdata = (cs_prev && !mute_prev) ? (addr_prev >> 1) : $urandom;
    cs_prev   = bus.slv_cs;
    mute_prev = slv_mute;
    addr_prev = bus.slv_addr;
    spur_next = 1'b0;
  endtask

  task automatic set_req(input logic idx, input logic r, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] b);
    if (idx == M1) begin
      bus.m1_req = r; bus.m1_addr = a; bus.m1_wdata = w; bus.m1_bytesel = b;
    end else begin
      bus.m0_req = r; bus.m0_addr = a; bus.m0_wdata = w; bus.m0_bytesel = b;
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {22'd0, bus.slv_cs, bus.slv_addr, bus.slv_wdata, bus.slv_bytesel,
            bus.m0_ack, bus.m0_rdata, bus.m0_err,
            bus.m1_ack, bus.m1_rdata, bus.m1_err, bus.busy};
  endfunction

  task automatic apply_reset();
    resetn = 1'b0;
    set_req(M0, 1'b0, '0, '0, '0);
    set_req(M1, 1'b0, '0, '0, '0);
    slv_mute = 1'b0;
    cycle();
    cycle();
    resetn = 1'b1;
  endtask

  task automatic wait_ack(input logic idx, output int lat);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if ((idx == M1) ? bus.m1_ack : bus.m0_ack) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  initial begin
    vecs[0] = '{M0, 32'h0,  32'h41, BYTESEL_WRITE, 1'b0, 32'h0,        1'b0, 3};
    vecs[1] = '{M1, 32'h4,  32'h0,  4'b1111,       1'b0, 32'h2,        1'b0, 3};
    vecs[2] = '{M0, 32'h8,  32'h77, BYTESEL_WRITE, 1'b1, 32'hDEAD_BEEF, 1'b1, T + 2};
    vecs[3] = '{M0, 32'h10, 32'h0,  4'b0011,       1'b0, 32'h8,        1'b0, 3};
    vecs[4] = '{M1, 32'hC,  32'h5A, BYTESEL_WRITE, 1'b0, 32'h6,        1'b0, 3};

    bus.slv_ack = 1'b0;
    bus.slv_rdata = '0;
    apply_reset();
    check("reset_outputs", all_outs(), '0);

    // Directed single transactions, one requester at a time.
    foreach (vecs[v]) begin
      int lat, cs_cnt;
      logic other;
      logic [31:0] rd, ad, wd;
      logic [3:0] bsd;
      logic er;
      lat = -1; cs_cnt = 0; other = 1'b0;
      rd = '0; ad = '0; wd = '0; bsd = '0; er = 1'b0;
      cycle();
      set_req(vecs[v].idx, 1'b1, vecs[v].addr, vecs[v].wdata, vecs[v].bs);
      slv_mute = vecs[v].mute;
      for (int k = 0; k < 40; k++) begin
        cycle();
        if (bus.slv_cs) begin
          cs_cnt++;
          ad = bus.slv_addr; wd = bus.slv_wdata; bsd = bus.slv_bytesel;
        end
        other |= (vecs[v].idx == M1) ? bus.m0_ack : bus.m1_ack;
        if ((vecs[v].idx == M1) ? bus.m1_ack : bus.m0_ack) begin
          lat = k + 1;
          rd = (vecs[v].idx == M1) ? bus.m1_rdata : bus.m0_rdata;
          er = (vecs[v].idx == M1) ? bus.m1_err : bus.m0_err;
          break;
        end
      end
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v), er, vecs[v].exp_err);
      check($sformatf("vec%0d_slv_fields", v), {ad, wd, bsd},
            {vecs[v].addr, vecs[v].wdata, vecs[v].bs});
      cycle();
      set_req(vecs[v].idx, 1'b0, '0, '0, '0);
      slv_mute = 1'b0;
      cs_cnt += int'(bus.slv_cs);
      other |= bus.m0_ack | bus.m1_ack;
      check($sformatf("vec%0d_rdata_hold_err_clr", v),
            (vecs[v].idx == M1) ? {bus.m1_rdata, bus.m1_err} : {bus.m0_rdata, bus.m0_err},
            {vecs[v].exp_rdata, 1'b0});
      cycle();
      cs_cnt += int'(bus.slv_cs);
      check($sformatf("vec%0d_cs_pulses", v), cs_cnt, 1);
      check($sformatf("vec%0d_other_ack", v), other, 1'b0);
    end

    // Contention from reset: both held high, four transactions.
    begin
      int n_ack, both, ack_cyc[4];
      logic order[4];
      n_ack = 0; both = 0;
      apply_reset();
      cycle();
      set_req(M0, 1'b1, 32'h100, 32'h1, BYTESEL_WRITE);
      set_req(M1, 1'b1, 32'h200, 32'h2, BYTESEL_WRITE);
      for (int k = 0; k < 40 && n_ack < 4; k++) begin
        cycle();
        if (bus.m0_ack && bus.m1_ack) both++;
        if (bus.m0_ack || bus.m1_ack) begin
          order[n_ack] = bus.m1_ack;
          ack_cyc[n_ack] = cyc;
          n_ack++;
          if (bus.m1_ack) set_req(M1, 1'b1, 32'h200 + 32'(n_ack), 32'h2, BYTESEL_WRITE);
          else            set_req(M0, 1'b1, 32'h100 + 32'(n_ack), 32'h1, BYTESEL_WRITE);
        end
      end
      set_req(M0, 1'b0, '0, '0, '0);
      set_req(M1, 1'b0, '0, '0, '0);
      check("cont_ack_count", n_ack, 4);
      check("cont_double_ack", both, 0);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("cont_order%0d", k), (k < n_ack) ? order[k] : 1'bx, (k % 2 == 0) ? M0 : M1);
      end
      for (int k = 1; k < 4; k++) begin
        check($sformatf("cont_period%0d", k), (k < n_ack) ? ack_cyc[k] - ack_cyc[k-1] : -1, 4);
      end
      cycle();
      cycle();
    end

    // Spurious ack while idle.
    spur_next = 1'b1;
    cycle();
    check("spur_ack_driven", bus.slv_ack, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("spur_idle%0d", k), {bus.busy, bus.slv_cs, bus.m0_ack, bus.m1_ack}, 4'b0000);
      cycle();
    end

    // Reset in WAIT: last_grant must return to 1 so the next tie goes to m0.
    begin
      int lat, acks;
      cycle();
      set_req(M0, 1'b1, 32'h20, 32'h0, 4'b1111);
      wait_ack(M0, lat);
      check("rstwait_prep_latency", lat, 3);
      set_req(M0, 1'b1, 32'h24, 32'h0, 4'b1111);
      cycle();
      slv_mute = 1'b1;
      cycle();
      check("rstwait_strobe", bus.slv_cs, 1'b1);
      cycle();
      check("rstwait_in_wait", {bus.busy, bus.slv_cs}, 2'b10);
      resetn = 1'b0;
      #1;
      check("rstwait_outputs_zero", all_outs(), '0);
      set_req(M0, 1'b0, '0, '0, '0);
      cycle();
      resetn = 1'b1;
      slv_mute = 1'b0;
      acks = 0;
      for (int k = 0; k < 24; k++) begin
        cycle();
        acks += int'(bus.m0_ack) + int'(bus.m1_ack);
      end
      check("rstwait_no_ack", acks, 0);
      set_req(M0, 1'b1, 32'h30, 32'h0, 4'b1111);
      set_req(M1, 1'b1, 32'h34, 32'h0, 4'b1111);
      lat = -1;
      for (int k = 0; k < 10; k++) begin
        cycle();
        if (bus.m0_ack || bus.m1_ack) begin
          lat = k + 1;
          check("rstwait_tie_winner", {bus.m0_ack, bus.m1_ack}, 2'b10);
          break;
        end
      end
      check("rstwait_tie_latency", lat, 3);
      set_req(M0, 1'b0, '0, '0, '0);
      set_req(M1, 1'b0, '0, '0, '0);
      cycle();
      cycle();
    end

    // Random traffic against a schedule model built from the timing rules.
    begin
      int base, rc, t_free, gap[2], resp;
      logic pend[2], saw[2], m_last, w, mute;
      logic [31:0] ra[2], rw[2];
      logic [3:0] rb[2];
      for (int k = 0; k < DEPTH; k++) begin
        exp_cs[k] = 0; exp_busy[k] = 0; exp_ack0[k] = 0; exp_ack1[k] = 0;
        exp_rd[k] = '0; exp_err[k] = 0; exp_addr[k] = '0; exp_wd[k] = '0; exp_bs[k] = '0;
      end
      apply_reset();
      base = cyc;
      t_free = 0;
      m_last = 1'b1;
      for (int j = 0; j < 2; j++) begin
        pend[j] = 1'b0; saw[j] = 1'b0; gap[j] = $urandom_range(0, 3);
        ra[j] = '0; rw[j] = '0; rb[j] = '0;
      end
      for (int i = 0; i < N_RND; i++) begin
        cycle();
        rc = cyc - base;
        check("rnd_ctl", {bus.slv_cs, bus.m0_ack, bus.m1_ack, bus.busy},
              {exp_cs[rc], exp_ack0[rc], exp_ack1[rc], exp_busy[rc]});
        if (exp_ack0[rc]) check("rnd_m0_data", {bus.m0_rdata, bus.m0_err}, {exp_rd[rc], exp_err[rc]});
        if (exp_ack1[rc]) check("rnd_m1_data", {bus.m1_rdata, bus.m1_err}, {exp_rd[rc], exp_err[rc]});
        if (exp_cs[rc])
          check("rnd_slv_fields", {bus.slv_addr, bus.slv_wdata, bus.slv_bytesel},
                {exp_addr[rc], exp_wd[rc], exp_bs[rc]});

        for (int j = 0; j < 2; j++) begin
          if (pend[j] && saw[j]) begin
            pend[j] = 1'b0;
            gap[j] = $urandom_range(0, 3);
            set_req(j[0], 1'b0, '0, '0, '0);
          end
          if (!pend[j]) begin
            if (gap[j] == 0 && i < N_RND - 30) begin
              pend[j] = 1'b1;
              ra[j] = {$urandom_range(0, 255), 2'b00};
              rw[j] = $urandom;
              rb[j] = ($urandom_range(0, 1) == 0) ? BYTESEL_WRITE : 4'($urandom);
              set_req(j[0], 1'b1, ra[j], rw[j], rb[j]);
            end else if (gap[j] > 0) begin
              gap[j]--;
            end
          end
          saw[j] = (j == 0) ? bus.m0_ack : bus.m1_ack;
        end

        if (rc >= t_free && (pend[0] || pend[1])) begin
          if (pend[0] && pend[1]) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
          else                    w = pend[1];
          m_last = w;
          mute = ($urandom_range(0, 9) == 0);
          slv_mute = mute;
          exp_cs[rc+1] = 1'b1;
          exp_addr[rc+1] = ra[w]; exp_wd[rc+1] = rw[w]; exp_bs[rc+1] = rb[w];
          resp = mute ? rc + 2 + T : rc + 3;
          for (int b = rc + 1; b <= resp; b++) exp_busy[b] = 1'b1;
          if (w) exp_ack1[resp] = 1'b1;
          else   exp_ack0[resp] = 1'b1;
          exp_rd[resp]  = mute ? 32'hDEAD_BEEF : (ra[w] >> 1);
          exp_err[resp] = mute;
          t_free = resp + 1;
        end
        spur_next = (rc + 1 >= t_free) && ($urandom_range(0, 7) == 0);
      end
      set_req(M0, 1'b0, '0, '0, '0);
      set_req(M1, 1'b0, '0, '0, '0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
